// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types.
// Used by fetch, decode and the immediate generator.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Registered head; flush empties it in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; head is qualified by count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !flush_i)
  );

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, credit-based request issue and redirect drop.
// Presents {pc, inst} to decode through fetch_fifo.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  logic [CW:0]   in_use;
  logic [CW-1:0] outst_after_resp;
  logic [31:0]   new_pc;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  wdata;

  assign in_use   = {1'b0, outst_q} + {1'b0, count};
  assign imem_req = !rst && !redirect && (in_use < (CW+1)'(DEPTH));
  assign accept   = imem_req && imem_ready;
  assign dropping = (drop_q != '0);
  assign push     = imem_rvalid && !redirect && !dropping;
  assign pop      = inst_valid && inst_ready && !redirect;
  assign new_pc   = align_pc(redirect_pc);

  assign outst_after_resp = outst_q - CW'(imem_rvalid);

  assign wdata.pc   = resp_pc_q;
  assign wdata.inst = imem_rdata;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_after_resp + CW'(accept);
    if (redirect) begin
      fetch_pc_d = new_pc;
      resp_pc_d  = new_pc;
      drop_d     = outst_after_resp;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   resp_pc_d  = resp_pc_q + 32'd4;
      if (imem_rvalid && dropping) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Idle outputs read as inst=0 so nothing downstream decodes garbage.
  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head.inst : '0;
  assign pc         = inst_valid ? head.pc : resp_pc_q;
  assign imem_addr  = fetch_pc_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order latency memory model.
// Each scenario task checks its own expectations.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] pq_addr[$];
  int          pq_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          cyc = 0;
  int          lat = 1;
  bit          toggle = 0;
  int          acc_cnt = 0;

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .pc          (pc)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  task automatic tick();
    bit acc;
    bit rv;
    #1;
    acc = imem_req && imem_ready;
    rv  = imem_rvalid;
    if (inst_valid && inst_ready && !redirect) begin
      got_pc.push_back(pc);
      got_inst.push_back(inst);
    end
    if (rv && pq_addr.size() > 0) begin
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    if (acc) begin
      pq_addr.push_back(imem_addr);
      pq_due.push_back(cyc + lat);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pq_addr[0]);
    end
    if (toggle) imem_ready = !imem_ready;
    #1;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got_pc.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_ready  = 1'b1;
    inst_ready  = 1'b0;
    toggle      = 0;
    lat         = 1;
    pq_addr.delete();
    pq_due.delete();
    tick();
    tick();
    rst = 1'b0;
    got_pc.delete();
    got_inst.delete();
    acc_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_ready  = 1'b1;
    inst_ready  = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req: got %b want 0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_addr: got %h want 0", imem_addr);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_out: got v=%b inst=%h pc=%h want 0/0/0",
               inst_valid, inst, pc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h want 1/0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_basic();
    do_reset();
    inst_ready = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL lat_early: got valid=%b want 0", inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h0050_0093) begin
      errors++;
      $display("FAIL lat_first: got v=%b pc=%h inst=%h want 1/0/00500093",
               inst_valid, pc, inst);
    end
    run_until(3, 40);
    checks++;
    if (got_pc.size() < 3) begin
      errors++; $display("FAIL basic_timeout: got %0d entries want 3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== memf(32'(4 * i))) begin
          errors++;
          $display("FAIL basic_seq%0d: got pc=%h inst=%h want pc=%h inst=%h",
                   i, got_pc[i], got_inst[i], 32'(4 * i), memf(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    repeat (10) tick();
    checks++;
    if (acc_cnt !== 2) begin
      errors++; $display("FAIL bp_accepts: got %0d want 2", acc_cnt);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL bp_req: got %b want 0", imem_req);
    end
    checks++;
    if (inst_valid !== 1'b1 || pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_head: got v=%b pc=%h want 1/0", inst_valid, pc);
    end
    inst_ready = 1'b1;
    run_until(3, 40);
    checks++;
    if (got_pc.size() < 3) begin
      errors++; $display("FAIL bp_timeout: got %0d entries want 3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== memf(32'(4 * i))) begin
          errors++;
          $display("FAIL bp_seq%0d: got pc=%h inst=%h want pc=%h",
                   i, got_pc[i], got_inst[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stall_latency();
    bit          stalled;
    logic [31:0] held;
    int          stalls;
    do_reset();
    lat        = 3;
    toggle     = 1;
    inst_ready = 1'b1;
    stalls     = 0;
    for (int i = 0; i < 300 && got_pc.size() < 6; i++) begin
      #1;
      stalled = imem_req && !imem_ready;
      held    = imem_addr;
      tick();
      if (stalled && imem_req) begin
        stalls++;
        checks++;
        if (imem_addr !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", imem_addr, held);
        end
      end
    end
    checks++;
    if (stalls == 0) begin
      errors++; $display("FAIL stall_seen: got 0 stalls want >0");
    end
    checks++;
    if (got_pc.size() < 6) begin
      errors++; $display("FAIL stall_timeout: got %0d entries want 6", got_pc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== memf(32'(4 * i))) begin
          errors++;
          $display("FAIL stall_seq%0d: got pc=%h inst=%h want pc=%h",
                   i, got_pc[i], got_inst[i], 32'(4 * i));
        end
      end
    end
    toggle = 0;
  endtask

  task automatic test_redirect();
    do_reset();
    lat        = 3;
    inst_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (acc_cnt !== 2 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_pre: got acc=%0d req=%b want 2/0", acc_cnt, imem_req);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_req: got %b want 0", imem_req);
    end
    tick();
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL redir_valid: got %b want 0", inst_valid);
    end
    inst_ready = 1'b1;
    run_until(2, 60);
    checks++;
    if (got_pc.size() < 2) begin
      errors++; $display("FAIL redir_timeout: got %0d entries want 2", got_pc.size());
    end else begin
      checks++;
      if (got_pc[0] !== 32'h100 || got_inst[0] !== memf(32'h100)) begin
        errors++;
        $display("FAIL redir_first: got pc=%h inst=%h want pc=00000100 inst=%h",
                 got_pc[0], got_inst[0], memf(32'h100));
      end
      checks++;
      if (got_pc[1] !== 32'h104 || got_inst[1] !== memf(32'h104)) begin
        errors++;
        $display("FAIL redir_second: got pc=%h inst=%h want pc=00000104",
                 got_pc[1], got_inst[1]);
      end
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    inst_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (inst_valid !== 1'b1 || imem_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL same_pre: got valid=%b rvalid=%b want 1/1",
               inst_valid, imem_rvalid);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL same_valid: got %b want 0", inst_valid);
    end
    run_until(1, 40);
    checks++;
    if (got_pc.size() < 1) begin
      errors++; $display("FAIL same_timeout: got 0 entries want 1");
    end else begin
      checks++;
      if (got_pc[0] !== 32'h40 || got_inst[0] !== memf(32'h40)) begin
        errors++;
        $display("FAIL same_next: got pc=%h inst=%h want pc=00000040 inst=%h",
                 got_pc[0], got_inst[0], memf(32'h40));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 1'b0;
    repeat (8) tick();
    checks++;
    if (inst_valid !== 1'b1 || pq_addr.size() != 0) begin
      errors++;
      $display("FAIL mid_pre: got valid=%b pending=%0d want 1/0",
               inst_valid, pq_addr.size());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL mid_out: got v=%b pc=%h want 0/0", inst_valid, pc);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL mid_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    got_pc.delete();
    got_inst.delete();
    inst_ready = 1'b1;
    run_until(2, 40);
    checks++;
    if (got_pc.size() < 2) begin
      errors++; $display("FAIL mid_timeout: got %0d entries want 2", got_pc.size());
    end else begin
      checks++;
      if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin
        errors++;
        $display("FAIL mid_seq: got %h %h want 00000000 00000004",
                 got_pc[0], got_pc[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall_latency();
    test_redirect();
    test_redirect_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
